cpu_mem_responder: RTL
======================

Name: cpu_mem_responder

Overview:
Memory responder on the far end of the CPU's instruction/data memory interface. It serves instruction fetches on `inst_addr`/`instr` and data loads/stores on `data_addr`/`data_in`/`mem_read`/`mem_write`/`data_out`. The storage is a single unified word array, preloaded through a load port before the CPU runs. The block also detects the EOF fetch address, flags illegal accesses and counts memory traffic for the bench.

Parameters:
BASE_ADDR, 32'h0000_3000, byte address of word 0; the CPU reset PC.
DEPTH_WORDS, 1024, number of 32-bit words; power of two.
CNT_W, 32, width of the access counters.

Ports:
clk  in  1  system clock; all state changes on posedge.
rst_n  in  1  asynchronous active-low reset.
inst_addr  in  32  instruction byte address from the CPU.
instr  out  32  instruction word, combinational.
data_addr  in  32  data byte address.
data_in  in  32  store data from the CPU.
mem_read  in  1  load request.
mem_write  in  1  store request.
data_out  out  32  load data, combinational.
load_valid  in  1  preload write strobe.
load_addr  in  32  preload byte address.
load_data  in  32  preload word.
load_done  in  1  one-cycle pulse that ends preload.
running  out  1  1 in RUN state.
halted  out  1  1 in HALT state.
err  out  1  sticky illegal-access flag.
rd_count  out  CNT_W  loads serviced in RUN, saturating.
wr_count  out  CNT_W  stores serviced in RUN, saturating.

Behaviour:
- Address map:
  - An address is in range when `BASE_ADDR <= a < BASE_ADDR + 4*DEPTH_WORDS`.
  - An address is aligned when `a[1:0] == 0`.
  - Word index is `(a - BASE_ADDR) >> 2`.
  - Legal means in range and aligned.
- Reset (async, `rst_n=0`):
  - State goes to LOAD.
  - `running`, `halted`, `err` are 0.
  - `rd_count` and `wr_count` are 0.
  - Array contents are not cleared.
  - Reset asserted mid-RUN or mid-HALT returns to LOAD immediately.
- FSM states: LOAD, RUN, HALT.
  - LOAD to RUN on the posedge where `load_done=1`.
  - RUN to HALT on the posedge where `inst_addr == 32'hFFFF_FFFF`.
  - HALT is left only by reset.
- LOAD state:
  - `load_valid` with a legal `load_addr` writes `load_data` at the posedge.
  - An illegal `load_addr` sets `err` and writes nothing.
  - If `load_valid` and `load_done` are high in the same cycle, the write completes and the state still goes to RUN.
  - `instr` is NOP (32'h0000_0000) and `data_out` is 0.
  - `mem_read`/`mem_write` are ignored and not counted.
- RUN state, instruction port:
  - `instr` is `mem[idx(inst_addr)]` combinationally, 0-cycle latency.
  - `inst_addr == EOF` gives `instr = 32'hFFFF_FFFF` (HALT_INSTR, opcode 111111).
  - Any other illegal `inst_addr` gives NOP and sets `err`.
- RUN state, loads:
  - `mem_read=1` gives `data_out = mem[idx(data_addr)]` combinationally.
  - `data_out` is 0 when `mem_read=0` or the address is illegal; an illegal address sets `err`.
  - `rd_count` increments at the posedge of each legal read.
- RUN state, stores:
  - `mem_write=1` with a legal address writes `data_in` at the posedge.
  - A store to an illegal address is suppressed and sets `err`.
  - `wr_count` increments on each legal write.
- Simultaneous `mem_read` and `mem_write`:
  - The store is performed and `data_out` shows the pre-write word (read-before-write).
  - Only `wr_count` increments.
  - `err` is set.
- Same-word fetch and store: `instr` shows the old word in that cycle and the new word from the next cycle.
- HALT state:
  - `instr` is HALT_INSTR and `data_out` is 0.
  - Stores are suppressed; counters and `err` are frozen.
- Counters saturate at all-ones; no wrap.
- Load-port activity outside LOAD is ignored.
- `err` clears only on reset.

Decomposition:
- Shared package `cpu_mem_pkg`:
  - EOF_ADDR = 32'hFFFF_FFFF.
  - NOP_INSTR = 32'h0.
  - HALT_INSTR = 32'hFFFF_FFFF.
  - State encoding LOAD=2'd0, RUN=2'd1, HALT=2'd2.
  - Default BASE_ADDR.
- Sub-module `mem_array`: `DEPTH_WORDS` x 32, two asynchronous read ports (instruction, data), one synchronous write port.
  - The write source is muxed between the load port and the CPU store by FSM state.

Test Plan:
- Preload words at 0x3000 (0x2008_0005) and 0x3004 (0xFC00_0000), then pulse `load_done` -> `running=1` next cycle; `instr` = 0x2008_0005 at `inst_addr` 0x3000.
- In RUN, store 0xDEAD_BEEF to 0x3100, then load 0x3100 -> `data_out` = 0xDEAD_BEEF; `wr_count`=1, `rd_count`=1, `err`=0.
- Store to 0x3102 (misaligned) and load 0x0000_0000 (out of range) -> no write, `data_out`=0, `err`=1 and stays 1.
- `mem_read` and `mem_write` together to 0x3100 with `data_in` 0x1234_5678 -> `data_out` = 0xDEAD_BEEF that cycle, 0x1234_5678 on the next read; `wr_count` increments only.
- `inst_addr` = 0xFFFF_FFFF -> `instr` = 0xFFFF_FFFF, `halted=1` next cycle; a later store is ignored and counters are frozen.
- Assert `rst_n=0` mid-RUN -> all outputs 0 immediately, state LOAD; preloaded words still readable after the next `load_done`.

Source files
------------

// File: rtl/cpu_mem_pkg.sv
// Shared constants and types for the CPU memory responder.
package cpu_mem_pkg;

  localparam int unsigned WORD_W          = 32;
  localparam int unsigned DEF_DEPTH_WORDS = 1024;
  localparam int unsigned DEF_CNT_W       = 32;

  localparam logic [WORD_W-1:0] DEF_BASE_ADDR = 32'h0000_3000;
  localparam logic [WORD_W-1:0] EOF_ADDR      = 32'hFFFF_FFFF;
  localparam logic [WORD_W-1:0] NOP_INSTR     = 32'h0000_0000;
  localparam logic [WORD_W-1:0] HALT_INSTR    = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

endpackage

// File: rtl/cpu_mem_responder_if.sv
// CPU instruction/data bus plus the preload port.
// master: CPU/loader side drives addresses, store data and load strobes.
// slave : responder side returns instr and data_out.
interface cpu_mem_if;
  import cpu_mem_pkg::*;

  logic [WORD_W-1:0] inst_addr;
  logic [WORD_W-1:0] instr;
  logic [WORD_W-1:0] data_addr;
  logic [WORD_W-1:0] data_in;
  logic              mem_read;
  logic              mem_write;
  logic [WORD_W-1:0] data_out;
  logic              load_valid;
  logic [WORD_W-1:0] load_addr;
  logic [WORD_W-1:0] load_data;
  logic              load_done;

  modport master (
    output inst_addr, data_addr, data_in, mem_read, mem_write,
    output load_valid, load_addr, load_data, load_done,
    input  instr, data_out
  );

  modport slave (
    input  inst_addr, data_addr, data_in, mem_read, mem_write,
    input  load_valid, load_addr, load_data, load_done,
    output instr, data_out
  );
endinterface

// File: rtl/cpu_mem_responder_mem_array.sv
// Unified word store: two async read ports (fetch, data), one sync write port.
// Ports: clk, we/waddr/wdata (write), raddr_i/rdata_i (fetch), raddr_d/rdata_d (data).
module mem_array
  import cpu_mem_pkg::*;
#(
  parameter  int unsigned DEPTH_WORDS = DEF_DEPTH_WORDS,
  localparam int unsigned AW          = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [AW-1:0]     raddr_i,
  output logic [WORD_W-1:0] rdata_i,
  input  logic [AW-1:0]     raddr_d,
  output logic [WORD_W-1:0] rdata_d
);

  logic [WORD_W-1:0] mem [DEPTH_WORDS];

  // Contents survive reset so a preloaded image stays valid across restarts.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata_i = mem[raddr_i];
  assign rdata_d = mem[raddr_d];

endmodule

// File: rtl/cpu_mem_responder.sv
// Far-end memory responder for the CPU: preload, fetch/load/store service,
// EOF halt detection, sticky illegal-access flag and saturating traffic counters.
// Ports: clk, rst_n; bus (cpu_mem_if.slave); running, halted, err,
// rd_count, wr_count (registered status).
module cpu_mem_responder
  import cpu_mem_pkg::*;
#(
  parameter logic [WORD_W-1:0] BASE_ADDR   = DEF_BASE_ADDR,
  parameter int unsigned       DEPTH_WORDS = DEF_DEPTH_WORDS,
  parameter int unsigned       CNT_W       = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  cpu_mem_if.slave         bus,
  output logic             running,
  output logic             halted,
  output logic             err,
  output logic [CNT_W-1:0] rd_count,
  output logic [CNT_W-1:0] wr_count
);

  localparam int unsigned AW       = $clog2(DEPTH_WORDS);
  localparam logic [32:0] END_ADDR = 33'(BASE_ADDR) + 33'(4 * DEPTH_WORDS);

  // 33-bit compare keeps the upper bound correct when the window touches 4 GiB.
  function automatic logic legal(input logic [WORD_W-1:0] a);
    return (a >= BASE_ADDR) && (33'(a) < END_ADDR) && (a[1:0] == 2'b00);
  endfunction

  function automatic logic [AW-1:0] word_idx(input logic [WORD_W-1:0] a);
    return AW'((a - BASE_ADDR) >> 2);
  endfunction

  state_e state_q, state_d;

  logic              inst_legal, data_legal, load_legal;
  logic              we;
  logic [AW-1:0]     waddr;
  logic [WORD_W-1:0] wdata;
  logic [WORD_W-1:0] rdata_i, rdata_d;
  logic              err_set, rd_inc, wr_inc;

  assign inst_legal = legal(bus.inst_addr);
  assign data_legal = legal(bus.data_addr);
  assign load_legal = legal(bus.load_addr);

  mem_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_mem (
    .clk     (clk),
    .we      (we),
    .waddr   (waddr),
    .wdata   (wdata),
    .raddr_i (word_idx(bus.inst_addr)),
    .rdata_i (rdata_i),
    .raddr_d (word_idx(bus.data_addr)),
    .rdata_d (rdata_d)
  );

  // State register and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_LOAD;
      running  <= 1'b0;
      halted   <= 1'b0;
      err      <= 1'b0;
      rd_count <= '0;
      wr_count <= '0;
    end else begin
      state_q <= state_d;
      running <= (state_d == ST_RUN);
      halted  <= (state_d == ST_HALT);
      if (err_set) err <= 1'b1;
      if (rd_inc && (rd_count != '1)) rd_count <= rd_count + CNT_W'(1);
      if (wr_inc && (wr_count != '1)) wr_count <= wr_count + CNT_W'(1);
    end
  end

  // Next state, write-port mux, bus responses and event strobes.
  always_comb begin
    state_d      = state_q;
    we           = 1'b0;
    waddr        = word_idx(bus.load_addr);
    wdata        = bus.load_data;
    bus.instr    = NOP_INSTR;
    bus.data_out = '0;
    err_set      = 1'b0;
    rd_inc       = 1'b0;
    wr_inc       = 1'b0;

    case (state_q)
      ST_LOAD: begin
        we      = bus.load_valid && load_legal;
        err_set = bus.load_valid && !load_legal;
        if (bus.load_done) state_d = ST_RUN;
      end
      ST_RUN: begin
        waddr = word_idx(bus.data_addr);
        wdata = bus.data_in;
        we    = bus.mem_write && data_legal;
        if (bus.inst_addr == EOF_ADDR) begin
          bus.instr = HALT_INSTR;
          state_d   = ST_HALT;
        end else if (inst_legal) begin
          bus.instr = rdata_i;
        end
        // Async read sees the array before this edge's store: read-before-write.
        if (bus.mem_read && data_legal) bus.data_out = rdata_d;
        rd_inc  = bus.mem_read && !bus.mem_write && data_legal;
        wr_inc  = bus.mem_write && data_legal;
        err_set = ((bus.inst_addr != EOF_ADDR) && !inst_legal)
                || ((bus.mem_read || bus.mem_write) && !data_legal)
                || (bus.mem_read && bus.mem_write);
      end
      ST_HALT: begin
        bus.instr = HALT_INSTR;
      end
      default: state_d = ST_LOAD;
    endcase
  end

endmodule
